// File: rtl/fpnew_req_arbiter_pkg.sv
// Shared types for the fpnew request arbiter: FPU control word layout and arbiter FSM states.
package fpnew_arb_pkg;

    typedef struct packed {
        logic [2:0] round_mode;
        logic [3:0] op;
        logic       op_mod;
        logic       vectorial_op;
        logic [2:0] fp_fmt;
        logic [2:0] fp_fmt2;
        logic [1:0] int_fmt;
        logic [6:0] prec_ctl;
    } fpu_ctrl_t;

    localparam int CTRL_W = $bits(fpu_ctrl_t);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FLUSH = 2'd2
    } arb_state_e;

endpackage

// File: rtl/fpnew_req_arbiter_if.sv
// Requester-side and FPU-side handshake bundle of the arbiter; slave = arbiter view, master = environment view.
interface fpnew_req_arbiter_if #(
    parameter int WIDTH   = 64,
    parameter int NUM_REQ = 4
);
    import fpnew_arb_pkg::*;

    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]         req_valid_i;
    logic [NUM_REQ-1:0]         req_ready_o;
    logic [NUM_REQ*3*WIDTH-1:0] req_operands_i;
    logic [NUM_REQ*CTRL_W-1:0]  req_ctrl_i;
    logic                       flush_i;
    logic [NUM_REQ-1:0]         rsp_valid_o;
    logic [NUM_REQ-1:0]         rsp_ready_i;
    logic [WIDTH-1:0]           rsp_z_o;
    logic [4:0]                 rsp_status_o;
    logic [3*WIDTH-1:0]         fpu_operands_o;
    logic [CTRL_W-1:0]          fpu_ctrl_o;
    logic [IDW-1:0]             fpu_tag_o;
    logic                       fpu_in_vld_o;
    logic                       fpu_in_rdy_i;
    logic                       fpu_flush_o;
    logic [WIDTH-1:0]           fpu_z_i;
    logic [4:0]                 fpu_status_i;
    logic [IDW-1:0]             fpu_tag_i;
    logic                       fpu_out_vld_i;
    logic                       fpu_out_rdy_o;

    modport slave (
        input  req_valid_i, req_operands_i, req_ctrl_i, flush_i, rsp_ready_i,
               fpu_in_rdy_i, fpu_z_i, fpu_status_i, fpu_tag_i, fpu_out_vld_i,
        output req_ready_o, rsp_valid_o, rsp_z_o, rsp_status_o, fpu_operands_o,
               fpu_ctrl_o, fpu_tag_o, fpu_in_vld_o, fpu_flush_o, fpu_out_rdy_o
    );

    modport master (
        output req_valid_i, req_operands_i, req_ctrl_i, flush_i, rsp_ready_i,
               fpu_in_rdy_i, fpu_z_i, fpu_status_i, fpu_tag_i, fpu_out_vld_i,
        input  req_ready_o, rsp_valid_o, rsp_z_o, rsp_status_o, fpu_operands_o,
               fpu_ctrl_o, fpu_tag_o, fpu_in_vld_o, fpu_flush_o, fpu_out_rdy_o
    );

endinterface

// File: rtl/fpnew_req_arbiter_rr.sv
// Round-robin picker: first eligible index after the last accepted one; pointer moves only on accept.
module fpnew_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         elig,
    input  logic                       accept,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] win_idx,
    output logic                       any_elig
);

    localparam int IDW = $clog2(NUM_REQ);

    logic [IDW-1:0] ptr_reg;

    always_comb begin
        int j;
        j        = 0;
        grant    = '0;
        win_idx  = '0;
        any_elig = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            j = int'(ptr_reg) + off;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!any_elig && elig[j]) begin
                any_elig = 1'b1;
                grant[j] = 1'b1;
                win_idx  = IDW'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= IDW'(NUM_REQ - 1);
        end else if (accept) begin
            ptr_reg <= win_idx;
        end
    end

endmodule

// File: rtl/fpnew_req_arbiter.sv
// Shares one FPU between NUM_REQ requesters: credit-limited round-robin issue, tag-routed results.
// Optional FPNEW_ARB_PERF_EN adds saturating per-requester issued-op counters on perf_issued_o.
module fpnew_req_arbiter
    import fpnew_arb_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int NUM_REQ = 4,
    parameter int MAX_OUT = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    fpnew_req_arbiter_if.slave  bus
`ifdef FPNEW_ARB_PERF_EN
    ,
    output logic [NUM_REQ*32-1:0] perf_issued_o
`endif
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(MAX_OUT + 1);
    localparam int OPW = 3 * WIDTH;

    arb_state_e         state_reg;
    logic               run_reg;
    logic [OPW-1:0]     ops_reg;
    logic [CTRL_W-1:0]  ctrl_reg;
    logic [IDW-1:0]     tag_reg;
    logic [CW-1:0]      cnt_reg [NUM_REQ];

    logic [NUM_REQ-1:0] elig, grant, tag_hit, res_dec, acc_vec;
    logic [IDW-1:0]     win_idx;
    logic               any_elig, can_load, open_gate, accept, ret_live, discard;
    logic [OPW-1:0]     sel_ops;
    logic [CTRL_W-1:0]  sel_ctrl;

    // run_reg keeps every combinational handshake output low while reset is held.
    assign can_load  = (state_reg == IDLE) || ((state_reg == BUSY) && bus.fpu_in_rdy_i);
    assign open_gate = run_reg && can_load && !bus.flush_i;
    assign accept    = open_gate && any_elig;
    assign ret_live  = run_reg && (state_reg != FLUSH) && !bus.flush_i;
    assign discard   = (state_reg == FLUSH) || bus.flush_i;

    assign bus.req_ready_o    = open_gate ? grant : '0;
    assign acc_vec            = bus.req_valid_i & bus.req_ready_o;
    assign bus.rsp_z_o        = bus.fpu_z_i;
    assign bus.rsp_status_o   = bus.fpu_status_i;
    assign bus.fpu_out_rdy_o  = run_reg && (discard || |(bus.rsp_ready_i & tag_hit));
    assign bus.fpu_operands_o = ops_reg;
    assign bus.fpu_ctrl_o     = ctrl_reg;
    assign bus.fpu_tag_o      = tag_reg;
    assign bus.fpu_in_vld_o   = (state_reg == BUSY);
    assign bus.fpu_flush_o    = (state_reg == FLUSH);

    fpnew_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .elig     (elig),
        .accept   (accept),
        .grant    (grant),
        .win_idx  (win_idx),
        .any_elig (any_elig)
    );

    always_comb begin
        sel_ops  = '0;
        sel_ctrl = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_ops  = bus.req_operands_i[i*OPW +: OPW];
                sel_ctrl = bus.req_ctrl_i[i*CTRL_W +: CTRL_W];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign tag_hit[gi]         = (bus.fpu_tag_i == IDW'(gi));
        assign elig[gi]            = bus.req_valid_i[gi] && (cnt_reg[gi] < CW'(MAX_OUT));
        assign bus.rsp_valid_o[gi] = ret_live && bus.fpu_out_vld_i && tag_hit[gi];
        assign res_dec[gi]         = bus.rsp_valid_o[gi] && bus.rsp_ready_i[gi];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_reg[gi] <= '0;
            end else if (bus.flush_i) begin
                cnt_reg[gi] <= '0;
            end else if (acc_vec[gi] && !res_dec[gi]) begin
                cnt_reg[gi] <= cnt_reg[gi] + CW'(1);
            end else if (!acc_vec[gi] && res_dec[gi] && (cnt_reg[gi] != '0)) begin
                cnt_reg[gi] <= cnt_reg[gi] - CW'(1);
            end
        end

        a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(res_dec[gi] && (cnt_reg[gi] == '0)));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            run_reg   <= 1'b0;
            ops_reg   <= '0;
            ctrl_reg  <= '0;
            tag_reg   <= '0;
        end else begin
            run_reg <= 1'b1;
            if (bus.flush_i) begin
                state_reg <= FLUSH;
                ops_reg   <= '0;
                ctrl_reg  <= '0;
                tag_reg   <= '0;
            end else begin
                if (accept) begin
                    ops_reg  <= sel_ops;
                    ctrl_reg <= sel_ctrl;
                    tag_reg  <= win_idx;
                end
                case (state_reg)
                    IDLE:    if (accept) state_reg <= BUSY;
                    BUSY:    if (bus.fpu_in_rdy_i && !accept) state_reg <= IDLE;
                    FLUSH:   state_reg <= IDLE;
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

`ifdef FPNEW_ARB_PERF_EN
    logic [31:0] perf_reg [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf
        // Flush does not clear these; only reset does.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                perf_reg[gi] <= '0;
            end else if (acc_vec[gi] && (perf_reg[gi] != 32'hFFFF_FFFF)) begin
                perf_reg[gi] <= perf_reg[gi] + 32'd1;
            end
        end
        assign perf_issued_o[gi*32 +: 32] = perf_reg[gi];
    end
`endif

endmodule

// File: tb/tb_fpnew_req_arbiter.sv
// Directed bench for fpnew_req_arbiter: reset, single op, round robin, credits, stall, flush, same-cycle credit.
module tb_fpnew_req_arbiter;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    fpnew_req_arbiter_if #(.WIDTH(64), .NUM_REQ(4)) bus ();

    fpnew_req_arbiter #(.WIDTH(64), .NUM_REQ(4), .MAX_OUT(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    function automatic logic [191:0] opat(input int i);
        return {64'hC000 + 64'(i), 64'hB000 + 64'(i), 64'hA000 + 64'(i)};
    endfunction

    function automatic logic [23:0] cpat(input int i);
        return 24'h5A0000 + 24'(i);
    endfunction

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_valid_i   = '0;
        bus.flush_i       = 1'b0;
        bus.rsp_ready_i   = '0;
        bus.fpu_in_rdy_i  = 1'b0;
        bus.fpu_z_i       = '0;
        bus.fpu_status_i  = '0;
        bus.fpu_tag_i     = '0;
        bus.fpu_out_vld_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni = 1'b0;
        clear_inputs();
        #3;
        rst_ni = 1'b1;
        nxt();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            bus.req_operands_i[i*192 +: 192] = opat(i);
            bus.req_ctrl_i[i*24 +: 24]       = cpat(i);
        end
        clear_inputs();

        // Reset held with every input trying to provoke a handshake
        bus.req_valid_i   = 4'b1111;
        bus.rsp_ready_i   = 4'b1111;
        bus.fpu_out_vld_i = 1'b1;
        bus.fpu_in_rdy_i  = 1'b1;
        #12;
        chk("rst_req_ready", bus.req_ready_o, 4'b0000);
        chk("rst_in_vld", bus.fpu_in_vld_o, 1'b0);
        chk("rst_flush", bus.fpu_flush_o, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid_o, 4'b0000);
        chk("rst_out_rdy", bus.fpu_out_rdy_o, 1'b0);
        do_reset();

        // Single op from req0 and its result
        bus.req_valid_i = 4'b0001; bus.fpu_in_rdy_i = 1'b1; #1;
        chk("one_ready", bus.req_ready_o, 4'b0001);
        chk("one_vld_pre", bus.fpu_in_vld_o, 1'b0);
        nxt(); bus.req_valid_i = 4'b0000; #1;
        chk("one_vld", bus.fpu_in_vld_o, 1'b1);
        chk("one_tag", bus.fpu_tag_o, 2'd0);
        chk("one_ops", bus.fpu_operands_o, opat(0));
        chk("one_ctrl", bus.fpu_ctrl_o, cpat(0));
        nxt(); #1;
        chk("one_vld_post", bus.fpu_in_vld_o, 1'b0);
        bus.fpu_out_vld_i = 1'b1; bus.fpu_tag_i = 2'd0; bus.rsp_ready_i = 4'b1111;
        bus.fpu_z_i = 64'h3FF0_0000_0000_0000; bus.fpu_status_i = 5'b00001; #1;
        chk("one_rsp_valid", bus.rsp_valid_o, 4'b0001);
        chk("one_out_rdy", bus.fpu_out_rdy_o, 1'b1);
        chk("one_rsp_z", bus.rsp_z_o, 64'h3FF0_0000_0000_0000);
        chk("one_rsp_status", bus.rsp_status_o, 5'b00001);
        nxt();
        do_reset();

        // All requesters valid, FPU always ready: tags 0,1,2,3,0 back to back
        begin
            logic [1:0] exp_tag [5];
            exp_tag = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
            bus.req_valid_i = 4'b1111; bus.fpu_in_rdy_i = 1'b1; #1;
            chk("rr_first_ready", bus.req_ready_o, 4'b0001);
            for (int k = 0; k < 5; k++) begin
                nxt();
                chk($sformatf("rr_vld_%0d", k), bus.fpu_in_vld_o, 1'b1);
                chk($sformatf("rr_tag_%0d", k), bus.fpu_tag_o, exp_tag[k]);
            end
        end
        do_reset();

        // Credit limit on req1: four accepts, then blocked until one result returns
        bus.req_valid_i = 4'b0010; bus.fpu_in_rdy_i = 1'b1; #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("cred_ready_%0d", k), bus.req_ready_o, 4'b0010);
            nxt();
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("cred_block_%0d", k), bus.req_ready_o, 4'b0000);
            nxt();
        end
        bus.fpu_out_vld_i = 1'b1; bus.fpu_tag_i = 2'd1; bus.rsp_ready_i = 4'b0010; #1;
        chk("cred_block_rsp", bus.req_ready_o, 4'b0000);
        chk("cred_rsp_valid", bus.rsp_valid_o, 4'b0010);
        chk("cred_out_rdy", bus.fpu_out_rdy_o, 1'b1);
        nxt(); bus.fpu_out_vld_i = 1'b0; bus.rsp_ready_i = 4'b0000; #1;
        chk("cred_resume", bus.req_ready_o, 4'b0010);
        do_reset();

        // FPU stalls for three cycles: issue register holds, nobody is accepted
        bus.req_valid_i = 4'b0101; bus.fpu_in_rdy_i = 1'b0; #1;
        chk("stall_ready0", bus.req_ready_o, 4'b0001);
        for (int k = 0; k < 3; k++) begin
            nxt();
            chk($sformatf("stall_vld_%0d", k), bus.fpu_in_vld_o, 1'b1);
            chk($sformatf("stall_ops_%0d", k), bus.fpu_operands_o, opat(0));
            chk($sformatf("stall_ctrl_%0d", k), bus.fpu_ctrl_o, cpat(0));
            chk($sformatf("stall_tag_%0d", k), bus.fpu_tag_o, 2'd0);
            chk($sformatf("stall_ready_%0d", k), bus.req_ready_o, 4'b0000);
        end
        bus.fpu_in_rdy_i = 1'b1; #1;
        chk("stall_drain_ready", bus.req_ready_o, 4'b0100);
        do_reset();

        // Flush with two ops in flight
        bus.req_valid_i = 4'b0011; bus.fpu_in_rdy_i = 1'b1; #1;
        chk("fl_acc0", bus.req_ready_o, 4'b0001);
        nxt();
        chk("fl_acc1", bus.req_ready_o, 4'b0010);
        nxt(); bus.flush_i = 1'b1; #1;
        chk("fl_req_ready_same", bus.req_ready_o, 4'b0000);
        nxt();
        bus.flush_i = 1'b0; bus.fpu_out_vld_i = 1'b1; bus.fpu_tag_i = 2'd0; bus.rsp_ready_i = 4'b0000; #1;
        chk("fl_flush", bus.fpu_flush_o, 1'b1);
        chk("fl_ready", bus.req_ready_o, 4'b0000);
        chk("fl_in_vld", bus.fpu_in_vld_o, 1'b0);
        chk("fl_out_rdy", bus.fpu_out_rdy_o, 1'b1);
        chk("fl_rsp_valid", bus.rsp_valid_o, 4'b0000);
        nxt(); bus.fpu_out_vld_i = 1'b0; bus.req_valid_i = 4'b0001; #1;
        chk("fl_flush_off", bus.fpu_flush_o, 1'b0);
        // A full set of four credits for req0 proves its counter was cleared
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("fl_cred_%0d", k), bus.req_ready_o, 4'b0001);
            nxt();
        end
        chk("fl_cred_block", bus.req_ready_o, 4'b0000);
        do_reset();

        // Result for req2 held by its requester, then accept and result in the same cycle
        bus.req_valid_i = 4'b0100; bus.fpu_in_rdy_i = 1'b1; #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("r2_acc_%0d", k), bus.req_ready_o, 4'b0100);
            nxt();
        end
        bus.req_valid_i = 4'b0000;
        bus.fpu_out_vld_i = 1'b1; bus.fpu_tag_i = 2'd2; bus.rsp_ready_i = 4'b0000;
        bus.fpu_z_i = 64'h4000_1234_5678_9ABC; bus.fpu_status_i = 5'b10000; #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("r2_hold_rdy_%0d", k), bus.fpu_out_rdy_o, 1'b0);
            chk($sformatf("r2_hold_vld_%0d", k), bus.rsp_valid_o, 4'b0100);
            chk($sformatf("r2_hold_z_%0d", k), bus.rsp_z_o, 64'h4000_1234_5678_9ABC);
            nxt();
        end
        bus.req_valid_i = 4'b0100; bus.rsp_ready_i = 4'b0100; #1;
        chk("r2_same_ready", bus.req_ready_o, 4'b0100);
        chk("r2_same_out_rdy", bus.fpu_out_rdy_o, 1'b1);
        nxt(); bus.fpu_out_vld_i = 1'b0; bus.rsp_ready_i = 4'b0000; #1;
        // Count must still be 3: exactly one more credit remains
        chk("r2_last_credit", bus.req_ready_o, 4'b0100);
        nxt();
        chk("r2_exhausted", bus.req_ready_o, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
